// File: rtl/apb_cmd_master_if.sv
// Command, response and APB bus signals of the APB command master.
// The master modport is the engine's view; slave is the environment's view.
interface apb_cmd_master_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err, rsp_timeout,
               PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err, rsp_timeout,
               PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB master engine: one command in, one SETUP/ACCESS sequence on APB, one response out.
// Supports PREADY wait states, PSLVERR capture and a bounded-wait timeout.
module apb_cmd_master #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_cmd_master_if.master    bus
);
    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_cmd_ready;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic              r_rsp_write;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rsp_timeout;

    logic              w_last_wait;

    // Last permitted wait cycle; PREADY=1 in this cycle still completes normally.
    assign w_last_wait = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_cmd_ready   <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_write   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        r_pwrite    <= bus.cmd_write;
                        r_paddr     <= bus.cmd_addr;
                        r_pwdata    <= bus.cmd_wdata;
                        r_psel      <= 1'b1;
                        r_penable   <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (bus.PREADY) begin
                        r_rsp_rdata   <= r_pwrite ? '0 : bus.PRDATA;
                        r_rsp_err     <= bus.PSLVERR;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_write   <= r_pwrite;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last_wait) begin
                            r_rsp_rdata   <= '0;
                            r_rsp_err     <= 1'b1;
                            r_rsp_timeout <= 1'b1;
                            r_rsp_write   <= r_pwrite;
                            r_psel        <= 1'b0;
                            r_penable     <= 1'b0;
                            r_rsp_valid   <= 1'b1;
                            r_state       <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.PSELx       = r_psel;
    assign bus.PENABLE     = r_penable;
    assign bus.PWRITE      = r_pwrite;
    assign bus.PADDR       = r_paddr;
    assign bus.PWDATA      = r_pwdata;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_write   = r_rsp_write;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Randomized self-checking bench for apb_cmd_master against a transaction-level model.
// A negedge-driven APB slave inserts the requested number of wait states per transfer.
module tb_apb_cmd_master;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 8;

    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    always #5 PCLK = ~PCLK;

    apb_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_cmd_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Slave behaviour: PREADY rises on ACCESS cycle number sl_wait (0-based);
    // PSLVERR and PRDATA are noise on every other cycle.
    int unsigned       sl_wait  = 0;
    logic              sl_err   = 1'b0;
    logic [DATA_W-1:0] sl_rdata = '0;
    int unsigned       acc_n    = 0;

    always @(negedge PCLK) begin
        if (bus.PSELx && bus.PENABLE) begin
            bus.PREADY  = (acc_n == sl_wait);
            bus.PSLVERR = bus.PREADY ? sl_err : 1'b1;
            bus.PRDATA  = bus.PREADY ? sl_rdata : DATA_W'($urandom);
            acc_n++;
        end else begin
            acc_n       = 0;
            bus.PREADY  = 1'($urandom);
            bus.PSLVERR = 1'($urandom);
            bus.PRDATA  = DATA_W'($urandom);
        end
    end

    task automatic run_txn(input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input int unsigned wt,
                           input logic err, input logic [DATA_W-1:0] rdata,
                           input int unsigned hold);
        int unsigned       exp_len;
        logic              exp_to;
        logic              exp_err;
        logic [DATA_W-1:0] exp_rd;
        int unsigned       c;
        int unsigned       guard;
        bit                bus_ok;
        bit                hold_ok;

        exp_to  = (wt >= TIMEOUT);
        exp_len = exp_to ? 1 + TIMEOUT : 2 + wt;
        exp_err = exp_to | err;
        exp_rd  = (exp_to || wr) ? '0 : rdata;
        sl_wait  = wt;
        sl_err   = err;
        sl_rdata = rdata;

        guard = 0;
        while (!bus.cmd_ready && guard < 50) begin
            @(negedge PCLK);
            guard++;
        end
        chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.rsp_ready = (hold == 0);
        @(negedge PCLK);

        c = 0;
        bus_ok = 1'b1;
        while (!bus.rsp_valid && c < 300) begin
            if (!(bus.PSELx && (bus.PENABLE == (c != 0)) && bus.PADDR == addr &&
                  bus.PWDATA == wdata && bus.PWRITE == wr && !bus.cmd_ready))
                bus_ok = 1'b0;
            // Commands offered mid-transfer must be ignored.
            bus.cmd_valid = 1'($urandom);
            bus.cmd_write = 1'($urandom);
            bus.cmd_addr  = ADDR_W'($urandom);
            bus.cmd_wdata = DATA_W'($urandom);
            c++;
            @(negedge PCLK);
        end
        chk("psel_cycles", c, exp_len);
        chk("apb_seq", 32'(bus_ok), 32'd1);
        chk("rsp_write", 32'(bus.rsp_write), 32'(wr));
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
        chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(exp_to));
        chk("resp_bus", 32'({bus.PSELx, bus.PENABLE, bus.cmd_ready}), 32'd0);

        bus.cmd_valid = 1'b1;
        hold_ok = 1'b1;
        for (int i = 0; i < int'(hold); i++) begin
            @(negedge PCLK);
            if (!(bus.rsp_valid && !bus.cmd_ready && !bus.PSELx &&
                  bus.rsp_write == wr && bus.rsp_rdata == exp_rd &&
                  bus.rsp_err == exp_err && bus.rsp_timeout == exp_to))
                hold_ok = 1'b0;
        end
        if (hold != 0) chk("rsp_hold", 32'(hold_ok), 32'd1);
        bus.rsp_ready = 1'b1;
        @(negedge PCLK);
        chk("after_handshake", 32'({bus.rsp_valid, bus.cmd_ready, bus.PSELx}), 32'b010);
        chk("paddr_kept", 32'(bus.PADDR), 32'(addr));
        chk("pwdata_kept", 32'(bus.PWDATA), 32'(wdata));
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned       r;
        int unsigned       wt;
        bit                seen;

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b1;
        PRESET = 1'b1;
        repeat (3) @(negedge PCLK);
        chk("rst_ctrl", 32'({bus.cmd_ready, bus.PSELx, bus.PENABLE, bus.PWRITE, bus.rsp_valid,
                             bus.rsp_write, bus.rsp_err, bus.rsp_timeout}), 32'b1000_0000);
        chk("rst_data", 32'({bus.PADDR, bus.PWDATA, bus.rsp_rdata}), 32'd0);
        PRESET = 1'b0;
        @(negedge PCLK);

        run_txn(1'b1, 4'h1, 8'hA5, 0, 1'b0, 8'h00, 0);
        run_txn(1'b0, 4'h1, 8'h00, 3, 1'b0, 8'h5A, 0);
        run_txn(1'b1, 4'h3, 8'h77, 2, 1'b1, 8'h00, 0);
        run_txn(1'b0, 4'h7, 8'h00, 255, 1'b0, 8'hC3, 1);
        run_txn(1'b0, 4'h7, 8'h00, TIMEOUT - 1, 1'b0, 8'hC3, 0);
        run_txn(1'b1, 4'h2, 8'h3C, 1, 1'b0, 8'h00, 5);
        for (int i = 0; i < 4; i++)
            run_txn(1'b1, ADDR_W'(8 + i), DATA_W'(8'h10 * i + 1), 0, 1'b0, 8'h00, 0);

        // Reset while stalled in ACCESS discards the transfer entirely.
        sl_wait = 1000;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 4'h5;
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        repeat (4) @(negedge PCLK);
        chk("stalled_access", 32'({bus.PSELx, bus.PENABLE}), 32'b11);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("rst_mid", 32'({bus.PSELx, bus.PENABLE, bus.rsp_valid, bus.cmd_ready}), 32'b0001);
        PRESET = 1'b0;
        seen = 1'b0;
        repeat (TIMEOUT + 4) begin
            @(negedge PCLK);
            if (bus.rsp_valid || bus.PSELx || !bus.cmd_ready) seen = 1'b1;
        end
        chk("no_stale_rsp", 32'(seen), 32'd0);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       wt = r % 4;
            else if (r == 7) wt = TIMEOUT - 1;
            else if (r == 8) wt = TIMEOUT;
            else             wt = 200;
            run_txn(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), wt,
                    1'($urandom), DATA_W'($urandom), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
